pzbcm_fifo_push_arbiter: RTL

PZBCM_FIFO_PUSH_ARBITER -- requirements
Module: pzbcm_fifo_push_arbiter

---
 rtl/pzbcm_fifo_push_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pzbcm_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pzbcm_fifo_push_arbiter
// Description : Round-robin, burst-locking arbiter for one shared FIFO push port.
// Revision    : 1.0 - initial release
// ============================================================================
module pzbcm_fifo_push_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [REQUESTERS-1:0]                i_request,
  input  logic [REQUESTERS-1:0]                i_last,
  input  logic [REQUESTERS-1:0][WIDTH-1:0]     i_data,
  output logic [REQUESTERS-1:0]                o_grant,
  input  logic                                 i_fifo_almost_full,
  input  logic                                 i_fifo_full,
  output logic                                 o_fifo_push,
  output logic [WIDTH-1:0]                     o_fifo_data,
  output logic                                 o_busy
);

  localparam int              c_OW       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int              c_CW       = $clog2(MAX_BURST + 1);
  localparam logic [0:0]      c_IDLE     = 1'b0;
  localparam logic [0:0]      c_LOCKED   = 1'b1;
  localparam logic [c_CW-1:0] c_MAX      = c_CW'(MAX_BURST);
  localparam logic [c_OW-1:0] c_LAST_IDX = c_OW'(REQUESTERS - 1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [c_OW-1:0] r_owner;
  logic [c_OW-1:0] w_owner_next;
  logic [c_OW-1:0] r_ptr;
  logic [c_OW-1:0] w_ptr_next;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_count_next;
  logic [c_CW-1:0] w_count_inc;
  logic            r_busy;

  logic [REQUESTERS-1:0][c_OW-1:0] w_rr_idx;
  logic                            w_found;
  logic [c_OW-1:0]                 w_cand;
  logic [c_OW-1:0]                 w_sel;
  logic                            w_accept;
  logic                            w_release;

  // Search order: w_rr_idx[k] is the requester visited k-th, starting at r_ptr.
  generate
    for (genvar g = 0; g < REQUESTERS; g++) begin : g_rr_idx
      logic [c_OW:0] w_sum;
      assign w_sum = {1'b0, r_ptr} + (c_OW + 1)'(g);
      assign w_rr_idx[g] = (w_sum >= (c_OW + 1)'(REQUESTERS))
                         ? c_OW'(w_sum - (c_OW + 1)'(REQUESTERS))
                         : w_sum[c_OW-1:0];
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_cand  = r_ptr;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      if (i_request[w_rr_idx[k]]) begin
        w_found = 1'b1;
        w_cand  = w_rr_idx[k];
      end
    end
  end

  // A new burst may not start near full; a held burst only stops on full.
  always_comb begin
    w_sel    = w_cand;
    w_accept = 1'b0;
    if (r_state == c_LOCKED) begin
      w_sel    = r_owner;
      w_accept = i_request[r_owner] && !i_fifo_full;
    end else begin
      w_accept = w_found && !i_fifo_full && !i_fifo_almost_full;
    end
  end

  assign w_count_inc = r_count + c_CW'(1);
  assign w_release   = i_last[w_sel] || (w_count_inc == c_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
      r_busy  <= (w_state_next == c_LOCKED);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    if (w_accept) begin
      w_owner_next = w_sel;
      if (w_release) begin
        w_state_next = c_IDLE;
        w_ptr_next   = (w_sel == c_LAST_IDX) ? '0 : w_sel + c_OW'(1);
        w_count_next = '0;
      end else begin
        w_state_next = c_LOCKED;
        w_count_next = w_count_inc;
      end
    end
  end

  always_comb begin
    o_grant     = '0;
    o_fifo_push = 1'b0;
    o_fifo_data = '0;
    if (w_accept && !i_rst) begin
      o_grant[w_sel] = 1'b1;
      o_fifo_push    = 1'b1;
      o_fifo_data    = i_data[w_sel];
    end
  end

  assign o_busy = r_busy;

endmodule
`default_nettype wire
